// File: rtl/router_ctrl_rr.sv
// Round-robin store-and-forward controller: grants one port, then sequences DEPTH store and DEPTH forward cycles.
// Latency: grant one cycle after a sampled request; all outputs registered.
// Backpressure: waits in ACK up to ACK_TIMEOUT cycles for acknowledge, abort cancels any phase.
module router_ctrl_rr #(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] request,
    input  logic                 acknowledge,
    input  logic                 abort,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 st_router,
    output logic                 fw_router,
    output logic [ADDR_W-1:0]    in_addr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 busy,
    output logic                 done
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW-1:0]     LAST_PORT = PW'(NUM_PORTS - 1);
    localparam logic [CW-1:0]     ACK_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {IDLE, ACK, STORE, FORWARD} state_t;

    state_t                 state, state_nx;
    logic [PW-1:0]          rr_ptr, rr_ptr_nx;
    logic [PW-1:0]          winner, winner_nx;
    logic [CW-1:0]          ack_cnt, ack_cnt_nx;
    logic [NUM_PORTS-1:0]   grant_nx;
    logic                   st_router_nx, fw_router_nx;
    logic [ADDR_W-1:0]      in_addr_nx, out_addr_nx;
    logic                   busy_nx, done_nx;

    logic                   pick_vld;
    logic [PW-1:0]          pick_idx;
    logic [PW-1:0]          ptr_after_winner;
    int                     scan_idx;

    // First requesting port at or after rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!pick_vld && request[PW'(scan_idx)]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(scan_idx);
            end
        end
    end

    assign ptr_after_winner = (winner == LAST_PORT) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            winner    <= '0;
            ack_cnt   <= '0;
            grant     <= '0;
            st_router <= 1'b0;
            fw_router <= 1'b0;
            in_addr   <= '0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            winner    <= winner_nx;
            ack_cnt   <= ack_cnt_nx;
            grant     <= grant_nx;
            st_router <= st_router_nx;
            fw_router <= fw_router_nx;
            in_addr   <= in_addr_nx;
            out_addr  <= out_addr_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        rr_ptr_nx    = rr_ptr;
        winner_nx    = winner;
        ack_cnt_nx   = ack_cnt;
        grant_nx     = grant;
        st_router_nx = st_router;
        fw_router_nx = fw_router;
        in_addr_nx   = in_addr;
        out_addr_nx  = out_addr;
        done_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    winner_nx  = pick_idx;
                    grant_nx   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
                    ack_cnt_nx = '0;
                    state_nx   = ACK;
                end
            end
            ACK: begin
                if (acknowledge) begin
                    state_nx     = STORE;
                    st_router_nx = 1'b1;
                    in_addr_nx   = '0;
                end else if (ack_cnt == ACK_LAST) begin
                    state_nx  = IDLE;
                    grant_nx  = '0;
                    rr_ptr_nx = ptr_after_winner;
                end else begin
                    ack_cnt_nx = ack_cnt + 1'b1;
                end
            end
            STORE: begin
                if (in_addr == ADDR_LAST) begin
                    state_nx     = FORWARD;
                    st_router_nx = 1'b0;
                    fw_router_nx = 1'b1;
                    out_addr_nx  = '0;
                    grant_nx     = '0;
                end else begin
                    in_addr_nx = in_addr + 1'b1;
                end
            end
            FORWARD: begin
                if (out_addr == ADDR_LAST) begin
                    state_nx     = IDLE;
                    fw_router_nx = 1'b0;
                    done_nx      = 1'b1;
                    rr_ptr_nx    = ptr_after_winner;
                end else begin
                    out_addr_nx = out_addr + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort wins over every other transition; addresses keep their last values.
        if (abort && state != IDLE) begin
            state_nx     = IDLE;
            grant_nx     = '0;
            st_router_nx = 1'b0;
            fw_router_nx = 1'b0;
            done_nx      = 1'b0;
            rr_ptr_nx    = ptr_after_winner;
            ack_cnt_nx   = ack_cnt;
            in_addr_nx   = in_addr;
            out_addr_nx  = out_addr;
        end

        busy_nx = (state_nx != IDLE);
    end
endmodule

// File: tb/tb_router_ctrl_rr.sv
module tb_router_ctrl_rr;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] request = '0;
    logic       acknowledge = 1'b1;
    logic       abort = 1'b0;
    logic [3:0] grant;
    logic       st_router, fw_router, busy, done;
    logic [3:0] in_addr, out_addr;

    logic [2:0] request3 = '0;
    logic       acknowledge3 = 1'b1;
    logic       abort3 = 1'b0;
    logic [2:0] grant3;
    logic       st_router3, fw_router3, busy3, done3;
    logic [1:0] in_addr3, out_addr3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_ctrl_rr #(.NUM_PORTS(4), .ADDR_W(4), .ACK_TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge), .abort(abort),
        .grant(grant), .st_router(st_router), .fw_router(fw_router),
        .in_addr(in_addr), .out_addr(out_addr), .busy(busy), .done(done)
    );

    router_ctrl_rr #(.NUM_PORTS(3), .ADDR_W(2), .ACK_TIMEOUT(4)) u_dut3 (
        .clk(clk), .rst(rst), .request(request3), .acknowledge(acknowledge3), .abort(abort3),
        .grant(grant3), .st_router(st_router3), .fw_router(fw_router3),
        .in_addr(in_addr3), .out_addr(out_addr3), .busy(busy3), .done(done3)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] order4 [5];
        logic [2:0] order3 [4];
        order4[0] = 4'b0001; order4[1] = 4'b0010; order4[2] = 4'b0100;
        order4[3] = 4'b1000; order4[4] = 4'b0001;
        order3[0] = 3'b001;  order3[1] = 3'b010;  order3[2] = 3'b100; order3[3] = 3'b001;

        // Reset state
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_st", 32'(st_router), 32'h0);
        check("rst_fw", 32'(fw_router), 32'h0);
        check("rst_in_addr", 32'(in_addr), 32'h0);
        check("rst_out_addr", 32'(out_addr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;

        // Single packet from port 0
        request = 4'b0001;
        tick();
        check("p1_grant_ack", 32'(grant), 32'h1);
        check("p1_busy", 32'(busy), 32'h1);
        check("p1_st_in_ack", 32'(st_router), 32'h0);
        request = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("p1_store_st", 32'(st_router), 32'h1);
            check("p1_store_addr", 32'(in_addr), 32'(i));
            check("p1_store_grant", 32'(grant), 32'h1);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            check("p1_fw", 32'(fw_router), 32'h1);
            check("p1_fw_addr", 32'(out_addr), 32'(i));
            check("p1_fw_grant", 32'(grant), 32'h0);
            check("p1_fw_st", 32'(st_router), 32'h0);
            check("p1_fw_done", 32'(done), 32'h0);
        end
        tick();
        check("p1_done", 32'(done), 32'h1);
        check("p1_done_busy", 32'(busy), 32'h0);
        check("p1_done_fw", 32'(fw_router), 32'h0);
        check("p1_out_addr_hold", 32'(out_addr), 32'hf);
        tick();
        check("p1_done_pulse", 32'(done), 32'h0);
        check("p1_idle_grant", 32'(grant), 32'h0);

        // Round robin with all ports requesting, 34-cycle packet period
        do_reset();
        request = 4'b1111;
        tick();
        check("rr_grant0", 32'(grant), 32'(order4[0]));
        for (int k = 1; k < 5; k++) begin
            repeat (33) tick();
            check("rr_done", 32'(done), 32'h1);
            check("rr_gap_grant", 32'(grant), 32'h0);
            tick();
            check("rr_grant", 32'(grant), 32'(order4[k]));
        end

        // Abort on the 5th store cycle of the port-0 packet
        request = 4'b0000;
        tick();
        check("ab_store0", 32'(in_addr), 32'h0);
        repeat (4) tick();
        check("ab_store4", 32'(in_addr), 32'h4);
        check("ab_store_st", 32'(st_router), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_st", 32'(st_router), 32'h0);
        check("ab_grant", 32'(grant), 32'h0);
        check("ab_done", 32'(done), 32'h0);
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_in_addr_hold", 32'(in_addr), 32'h4);

        // Acknowledge timeout; rr_ptr is 1 after the abort of port 0
        acknowledge = 1'b0;
        request = 4'b0100;
        tick();
        check("to_grant1", 32'(grant), 32'h4);
        request = 4'b0110;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("to_grant_held", 32'(grant), 32'h4);
        end
        tick();
        check("to_grant_drop", 32'(grant), 32'h0);
        check("to_done", 32'(done), 32'h0);
        check("to_busy", 32'(busy), 32'h0);
        tick();
        check("to_next_grant", 32'(grant), 32'h2);

        // Async reset in the middle of forwarding
        acknowledge = 1'b1;
        request = 4'b0000;
        repeat (24) tick();
        check("ar_fw", 32'(fw_router), 32'h1);
        check("ar_out7", 32'(out_addr), 32'h7);
        #2;
        rst = 1'b1;
        #1;
        check("ar_fw0", 32'(fw_router), 32'h0);
        check("ar_out0", 32'(out_addr), 32'h0);
        check("ar_in0", 32'(in_addr), 32'h0);
        check("ar_busy0", 32'(busy), 32'h0);
        check("ar_grant0", 32'(grant), 32'h0);
        tick();
        rst = 1'b0;
        request = 4'b1000;
        tick();
        check("ar_restart_grant", 32'(grant), 32'h8);
        request = 4'b0000;
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Three ports, four-word packets
        request3 = 3'b111;
        tick();
        check("p3_grant0", 32'(grant3), 32'(order3[0]));
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                check("p3_st", 32'(st_router3), 32'h1);
                check("p3_in_addr", 32'(in_addr3), 32'(i));
            end
            for (int i = 0; i < 4; i++) begin
                tick();
                check("p3_fw", 32'(fw_router3), 32'h1);
                check("p3_out_addr", 32'(out_addr3), 32'(i));
            end
            tick();
            check("p3_done", 32'(done3), 32'h1);
            tick();
            check("p3_grant", 32'(grant3), 32'(order3[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
